// File: rtl/reg_file24_if.sv
// Operand-read, writeback and ALU-flag bus between the datapath and reg_file24.
// The datapath drives addresses, write data and enables; the file returns operands and flags.
interface reg_file24_if #(
  parameter int AW = 4
);
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [23:0]   ReadData1;
  logic [23:0]   ReadData2;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [23:0]   WriteData;
  logic          FlagWrite;
  logic          ZeroIn;
  logic          OverflowIn;
  logic          CarryIn;
  logic          NegIn;
  logic [3:0]    Flags;
  logic          WriteAck;

  modport master (
    output ReadReg1,
    output ReadReg2,
    output RegWrite,
    output WriteReg,
    output WriteData,
    output FlagWrite,
    output ZeroIn,
    output OverflowIn,
    output CarryIn,
    output NegIn,
    input  ReadData1,
    input  ReadData2,
    input  Flags,
    input  WriteAck
  );

  modport slave (
    input  ReadReg1,
    input  ReadReg2,
    input  RegWrite,
    input  WriteReg,
    input  WriteData,
    input  FlagWrite,
    input  ZeroIn,
    input  OverflowIn,
    input  CarryIn,
    input  NegIn,
    output ReadData1,
    output ReadData2,
    output Flags,
    output WriteAck
  );
endinterface

// File: rtl/reg_file24.sv
// 24-bit register file with hardwired r0, optional write-to-read bypass,
// and the {N,C,V,Z} status-flag register for conditional branches.
module reg_file24 #(
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int BYPASS = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  reg_file24_if.slave bus
);

  logic [23:0] regs [NREGS];
  logic        wr_en;
  logic [23:0] rd1;
  logic [23:0] rd2;
  logic [3:0]  flags_q;
  logic        ack_q;

  // r0 is never a legal destination, so it never raises the strobe.
  assign wr_en = bus.RegWrite && (bus.WriteReg != '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      flags_q <= 4'b0000;
    end else if (bus.FlagWrite) begin
      flags_q <= {bus.NegIn, bus.CarryIn,
                  bus.OverflowIn, bus.ZeroIn};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wr_en;
    end
  end

  always_comb begin
    rd1 = regs[bus.ReadReg1];
    if (bus.ReadReg1 == '0) begin
      rd1 = '0;
    end else if ((BYPASS != 0) && wr_en &&
                 (bus.ReadReg1 == bus.WriteReg)) begin
      rd1 = bus.WriteData;
    end
  end

  always_comb begin
    rd2 = regs[bus.ReadReg2];
    if (bus.ReadReg2 == '0) begin
      rd2 = '0;
    end else if ((BYPASS != 0) && wr_en &&
                 (bus.ReadReg2 == bus.WriteReg)) begin
      rd2 = bus.WriteData;
    end
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;
  assign bus.Flags     = flags_q;
  assign bus.WriteAck  = ack_q;

endmodule

// File: tb/tb_reg_file24.sv
// Directed bench for reg_file24: one instance without bypass (a), one with (b),
// both driven by the same stimulus and checked against hand-computed values.
module tb_reg_file24;

  logic        clk;
  logic        rst;
  logic [3:0]  rr1;
  logic [3:0]  rr2;
  logic        rw;
  logic [3:0]  wr;
  logic [23:0] wd;
  logic        fw;
  logic        zi;
  logic        vi;
  logic        ci;
  logic        ni;

  int n_chk;
  int n_fail;

  reg_file24_if #(.AW(4)) bus_a ();
  reg_file24_if #(.AW(4)) bus_b ();

  assign bus_a.ReadReg1   = rr1;
  assign bus_a.ReadReg2   = rr2;
  assign bus_a.RegWrite   = rw;
  assign bus_a.WriteReg   = wr;
  assign bus_a.WriteData  = wd;
  assign bus_a.FlagWrite  = fw;
  assign bus_a.ZeroIn     = zi;
  assign bus_a.OverflowIn = vi;
  assign bus_a.CarryIn    = ci;
  assign bus_a.NegIn      = ni;

  assign bus_b.ReadReg1   = rr1;
  assign bus_b.ReadReg2   = rr2;
  assign bus_b.RegWrite   = rw;
  assign bus_b.WriteReg   = wr;
  assign bus_b.WriteData  = wd;
  assign bus_b.FlagWrite  = fw;
  assign bus_b.ZeroIn     = zi;
  assign bus_b.OverflowIn = vi;
  assign bus_b.CarryIn    = ci;
  assign bus_b.NegIn      = ni;

  reg_file24 #(.NREGS(16), .AW(4), .BYPASS(0)) dut_a (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_a.slave)
  );

  reg_file24 #(.NREGS(16), .AW(4), .BYPASS(1)) dut_b (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [23:0] obs,
                     input logic [23:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw = 1'b0; wr = '0; wd = '0;
    fw = 1'b0; zi = 1'b0; vi = 1'b0; ci = 1'b0; ni = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    rr1 = '0;
    rr2 = '0;
    idle();
    tick();
    rst = 1'b0;
    rr1 = 4'd5;
    rr2 = 4'd9;
    #1;
    chk("rst_rd1_a", bus_a.ReadData1, 24'h0);
    chk("rst_rd2_b", bus_b.ReadData2, 24'h0);
    chk("rst_flags_a", 24'(bus_a.Flags), 24'h0);
    chk("rst_ack_a", 24'(bus_a.WriteAck), 24'h0);

    for (int i = 1; i < 16; i++) begin
      rw = 1'b1;
      wr = 4'(i);
      wd = 24'(i) * 24'h010101;
      fw = 1'b1; zi = 1'b1; vi = 1'b1; ci = 1'b1; ni = 1'b1;
      tick();
    end
    idle();
    rr1 = 4'd1;
    rr2 = 4'd15;
    #1;
    chk("pre_r1_a", bus_a.ReadData1, 24'h010101);
    chk("pre_r15_b", bus_b.ReadData2, 24'h0f0f0f);
    chk("pre_flags_a", 24'(bus_a.Flags), 24'hf);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_r1_a", bus_a.ReadData1, 24'h0);
    chk("mid_rst_r15_a", bus_a.ReadData2, 24'h0);
    chk("mid_rst_r1_b", bus_b.ReadData1, 24'h0);
    chk("mid_rst_flags_a", 24'(bus_a.Flags), 24'h0);
    chk("mid_rst_flags_b", 24'(bus_b.Flags), 24'h0);
    chk("mid_rst_ack_a", 24'(bus_a.WriteAck), 24'h0);

    rw = 1'b1; wr = 4'd4; wd = 24'h444444;
    tick();
    wr = 4'd6; wd = 24'h666666;
    tick();
    wr = 4'd5; wd = 24'hABCDEF;
    tick();
    idle();
    rr1 = 4'd5;
    rr2 = 4'd5;
    #1;
    chk("wr_r5_p1_a", bus_a.ReadData1, 24'hABCDEF);
    chk("wr_r5_p2_a", bus_a.ReadData2, 24'hABCDEF);
    chk("wr_r5_p1_b", bus_b.ReadData1, 24'hABCDEF);
    chk("wr_ack_hi_a", 24'(bus_a.WriteAck), 24'h1);
    tick();
    rr1 = 4'd4;
    rr2 = 4'd6;
    #1;
    chk("wr_ack_lo_a", 24'(bus_a.WriteAck), 24'h0);
    chk("wr_r4_a", bus_a.ReadData1, 24'h444444);
    chk("wr_r6_a", bus_a.ReadData2, 24'h666666);

    rw = 1'b1; wr = 4'd0; wd = 24'hFFFFFF;
    rr1 = 4'd0;
    #1;
    chk("r0_byp_b", bus_b.ReadData1, 24'h0);
    tick();
    idle();
    #1;
    chk("r0_rd_a", bus_a.ReadData1, 24'h0);
    chk("r0_ack_a", 24'(bus_a.WriteAck), 24'h0);

    rw = 1'b1; wr = 4'd3; wd = 24'h000011;
    tick();
    wd = 24'h123456;
    rr1 = 4'd3;
    rr2 = 4'd3;
    #1;
    chk("rdw_old_a", bus_a.ReadData1, 24'h000011);
    chk("rdw_byp1_b", bus_b.ReadData1, 24'h123456);
    chk("rdw_byp2_b", bus_b.ReadData2, 24'h123456);
    tick();
    idle();
    #1;
    chk("rdw_new_a", bus_a.ReadData1, 24'h123456);
    chk("rdw_new_b", bus_b.ReadData1, 24'h123456);

    fw = 1'b1; zi = 1'b1; ci = 1'b1; vi = 1'b0; ni = 1'b0;
    tick();
    #1;
    chk("flag_set_a", 24'(bus_a.Flags), 24'b0101);
    fw = 1'b0; zi = 1'b0; ci = 1'b0; vi = 1'b1; ni = 1'b1;
    tick();
    chk("flag_hold_a", 24'(bus_a.Flags), 24'b0101);
    chk("flag_hold_b", 24'(bus_b.Flags), 24'b0101);
    fw = 1'b1;
    tick();
    idle();
    chk("flag_nv_a", 24'(bus_a.Flags), 24'b1010);

    rw = 1'b1; wr = 4'd9; wd = 24'hAAAAAA;
    rr1 = 4'd9;
    tick();
    chk("b2b_1_a", bus_a.ReadData1, 24'hAAAAAA);
    wd = 24'hBBBBBB;
    tick();
    chk("b2b_2_a", bus_a.ReadData1, 24'hBBBBBB);
    idle();
    tick();
    chk("b2b_hold_a", bus_a.ReadData1, 24'hBBBBBB);

    rst = 1'b1;
    rw = 1'b1; wr = 4'd7; wd = 24'h000777;
    fw = 1'b1; zi = 1'b1; vi = 1'b1; ci = 1'b1; ni = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    rr1 = 4'd7;
    #1;
    chk("rstp_r7_a", bus_a.ReadData1, 24'h0);
    chk("rstp_r7_b", bus_b.ReadData1, 24'h0);
    chk("rstp_flags_a", 24'(bus_a.Flags), 24'h0);
    chk("rstp_ack_a", 24'(bus_a.WriteAck), 24'h0);
    rw = 1'b1; wr = 4'd7; wd = 24'h000777;
    tick();
    idle();
    #1;
    chk("resume_r7_a", bus_a.ReadData1, 24'h000777);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file24.md
# reg_file24

Register file and status-flag register for the 24-bit single-cycle CPU. It sits on both sides of the 24-bit ALU. Its two combinational read ports supply the ALU A/B operands. On the clock edge it captures the writeback value (ALU Result or other selected data) and the ALU status outputs (Zero, Overflow, CarryOut, Result[23]) for use by conditional branches.

## Interface

Parameters:
- NREGS, 16: number of architectural registers; power of two, 2..16.
- AW, 4: register address width; NREGS = 2**AW.
- BYPASS, 0: 1 makes a read of the register being written in the same cycle return WriteData; 0 returns the stored value.

Ports:
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clears all registers and flags.
- ReadReg1  input  AW  address for port 1 (ALU A operand).
- ReadReg2  input  AW  address for port 2 (ALU B operand / store data).
- ReadData1  output  24  register[ReadReg1], combinational.
- ReadData2  output  24  register[ReadReg2], combinational.
- RegWrite  input  1  write enable for the register array.
- WriteReg  input  AW  destination address.
- WriteData  input  24  writeback value.
- FlagWrite  input  1  enable for flag capture.
- ZeroIn, OverflowIn, CarryIn, NegIn  input  1 each  ALU Zero, Overflow, CarryOut, Result[23].
- Flags  output  4  registered {N, C, V, Z}, bit 3 = N, bit 0 = Z.
- WriteAck  output  1  registered; high for one cycle after a write that changed the array (debug/verification strobe).

## Operation

- Register 0 is hardwired to 24'h000000. Writes to address 0 are discarded. Reads of address 0 return 0 regardless of BYPASS.
- Write: on a rising edge with RegWrite=1, Reset=0 and WriteReg≠0, register[WriteReg] ← WriteData. All other registers hold.
- Reads are purely combinational from the array; there is no read enable.
- BYPASS=1: if RegWrite=1, WriteReg≠0 and ReadRegN==WriteReg, then ReadDataN = WriteData in that same cycle. This applies to both ports independently.
- Flags: on a rising edge with FlagWrite=1 and Reset=0, Flags ← {NegIn, CarryIn, OverflowIn, ZeroIn}. Otherwise Flags hold.
- RegWrite and FlagWrite are independent; both may be asserted in the same cycle.
- WriteAck ← RegWrite & (WriteReg≠0) & ~Reset on every edge.
- Reset has priority over every write enable. A write presented in the Reset cycle is lost.
- Out-of-range addresses cannot occur because the array is a full 2**AW.
- No internal state machine. State consists of the array, Flags and WriteAck.

## Timing

- Reset values after the first Reset edge: every register = 0, Flags = 4'b0000, WriteAck = 0. Consequently ReadData1 = ReadData2 = 0 for any address.
- Read latency is 0 cycles (combinational from address to data).
- Write latency is 1 edge. With BYPASS=0 the new value is visible on ReadData starting from the cycle after the write edge.
- Flag latency is 1 edge. Flags reflect the ALU outputs present at the FlagWrite edge.
- Reset asserted mid-program clears everything at that edge. Operation resumes on the next edge after deassertion.
- Simultaneous read and write of the same address with BYPASS=0: the read returns the old value during the write cycle and the new value afterwards.
- Back-to-back writes to the same address on consecutive edges: the last write wins, and each write is visible for exactly one cycle per edge.

## Test plan

- Reset: preload registers 1..15 with nonzero values, assert Reset for 1 edge. Required: all ReadData = 0, Flags = 0, WriteAck = 0.
- Write/read: write 24'hABCDEF to r5, then read r5 on port 1 and r5 on port 2 the next cycle. Required: both ports = 24'hABCDEF, WriteAck = 1 for one cycle; r4 and r6 unchanged.
- r0 protection: write 24'hFFFFFF to r0. Required: ReadData for r0 = 0, WriteAck = 0.
- Same-cycle read-during-write of r3 (old value 24'h000011, new value 24'h123456):
  - BYPASS=0: ReadData1 = 24'h000011 during the write cycle, 24'h123456 after.
  - BYPASS=1: ReadData1 = 24'h123456 during the write cycle.
- Flags:
  - Apply ZeroIn=1, CarryIn=1, OverflowIn=0, NegIn=0 with FlagWrite=1. Required: Flags = 4'b0101.
  - Next cycle, apply different inputs with FlagWrite=0. Required: Flags remain 4'b0101.
- Reset priority: assert RegWrite=1 (r7 ← 24'h000777) and FlagWrite=1 in the same cycle as Reset. Required: r7 = 0 and Flags = 0 after that edge.
